// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared types and constants for the instruction-fetch stage.
//   - FetchState : fetch sequencer states (BOOT, RUN, FLUSH)
//   - FetchEntry : one buffered instruction together with the PC it came from
//   - INSTR_BYTES: byte stride between sequential fetches
//   - align_word : forces an address onto a 32-bit word boundary
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } FetchState;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } FetchEntry;

  // Redirect targets may carry low bits (JALR-style sums). Fetch always goes
  // to the containing word; the misalignment is reported separately.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Small synchronous FIFO, power-of-two DEPTH (>= 2). Used by fetch_unit both
//   as the decoded-instruction buffer (FetchEntry) and as the in-flight
//   request PC queue (32-bit PC).
//
//   Ports
//     clk, reset   : clock, asynchronous active-high reset
//     push / din   : write din when not full (or when full and popping)
//     pop  / dout  : remove head; dout shows the head, zero while empty
//     clear        : synchronous flush; any push/pop in the same cycle is lost
//     full, empty  : occupancy flags
//     count        : number of valid entries (0..DEPTH)
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter type         elem_t = FetchEntry
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  elem_t                    din,
  output elem_t                    dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  elem_t            mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left out of reset; validity is
  // tracked by the pointers and count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

  // Zero while empty so downstream outputs are clean after reset and flushes.
  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage sitting behind the branch decision unit. Owns the
//   PC, issues word fetches to instruction memory, buffers returned words and
//   hands them to decode with their PC. A taken redirect (branch_decision)
//   moves the PC to branch_target and throws away everything fetched before.
//
//   Ports
//     clk, reset         : clock, asynchronous active-high reset
//     branch_decision    : single-cycle taken-redirect strobe
//     branch_target      : redirect address (low two bits may be non-zero)
//     imem_req_valid/ready, imem_addr : fetch request channel
//     imem_rsp_valid/data: in-order response channel, latency >= 1 cycle
//     if_valid/ready     : decode handshake
//     if_instr, if_pc    : instruction and its fetch PC
//     if_pc_plus4        : link value for JAL/JALR
//     misaligned_target  : one-cycle pulse after a redirect with target[1:0]!=0
//
//   Sequencing
//     BOOT  : one idle cycle after reset release, never issues
//     RUN   : normal fetching
//     FLUSH : waiting for responses that belong to the abandoned path
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_decision,
  input  logic [31:0] branch_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        misaligned_target
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] CAP = (CNT_W + 1)'(FIFO_DEPTH);

  FetchState        state;
  logic [31:0]      pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;

  logic             redirect;
  logic             rsp_accept;
  logic             rsp_keep;
  logic             req_fire;
  logic [CNT_W:0]   occupancy;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] drop_next;
  logic [CNT_W-1:0] outstanding_next;

  // Instruction buffer
  FetchEntry        ibuf_din;
  FetchEntry        ibuf_dout;
  logic             ibuf_push;
  logic             ibuf_pop;
  logic             ibuf_full;
  logic             ibuf_empty;
  logic [CNT_W-1:0] ibuf_count;

  // In-flight request PC queue
  logic [31:0]      pcq_pc;
  logic             pcq_full;
  logic             pcq_empty;
  logic [CNT_W-1:0] pcq_count;

  // Redirects are meaningless before the first fetch has been sequenced.
  assign redirect = branch_decision && (state != BOOT);

  // Responses with nothing outstanding belong to requests issued before a
  // reset; they have no PC to pair with and are ignored outright.
  assign rsp_accept = imem_rsp_valid && (outstanding != '0);
  // Kept only when it is not owed to the flush and not killed by a redirect
  // arriving in the same cycle.
  assign rsp_keep   = rsp_accept && (drop_cnt == '0) && !redirect;

  assign if_valid = !ibuf_empty && !branch_decision;
  assign ibuf_pop = if_valid && if_ready;

  // Outstanding plus buffered fetches are capped at the buffer depth, so every
  // response is guaranteed a slot. The entry decode takes this cycle is
  // credited back immediately; without that the cap would stall every other
  // cycle and a depth-2 buffer could not sustain one instruction per cycle.
  assign occupancy = {1'b0, outstanding} + {1'b0, ibuf_count}
                   - (CNT_W + 1)'(ibuf_pop);

  assign imem_req_valid = (state == RUN) && !branch_decision && (occupancy < CAP);
  assign imem_addr      = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses still owed by memory once this cycle's arrival is counted.
  assign remaining        = outstanding - CNT_W'(rsp_accept);
  assign outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_accept);

  // NOTE: combinational blocks assign a default first so no path leaves the
  // output unassigned, which would otherwise infer a latch.
  always_comb begin
    drop_next = drop_cnt;
    if (redirect) begin
      // In FLUSH no new requests issue, so outstanding equals drop_cnt and
      // this is the same as the ordinary decrement.
      drop_next = remaining;
    end else if (rsp_accept && (drop_cnt != '0)) begin
      drop_next = drop_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= BOOT;
      pc                <= RESET_PC;
      outstanding       <= '0;
      drop_cnt          <= '0;
      misaligned_target <= 1'b0;
    end else begin
      outstanding       <= outstanding_next;
      drop_cnt          <= drop_next;
      misaligned_target <= redirect && (branch_target[1:0] != 2'b00);

      if (redirect) begin
        pc <= align_word(branch_target);
      end else if (req_fire) begin
        pc <= pc + 32'(INSTR_BYTES);
      end

      unique case (state)
        BOOT:    state <= RUN;
        RUN:     if (redirect && (remaining != '0)) state <= FLUSH;
        FLUSH:   if (drop_next == '0) state <= RUN;
        default: state <= BOOT;
      endcase
    end
  end

  assign ibuf_push = rsp_keep;
  assign ibuf_din  = '{instr: imem_rsp_data, pc: pcq_pc};

  fetch_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .elem_t (FetchEntry)
  ) u_ibuf (
    .clk   (clk),
    .reset (reset),
    .push  (ibuf_push),
    .pop   (ibuf_pop),
    .clear (redirect),
    .din   (ibuf_din),
    .dout  (ibuf_dout),
    .full  (ibuf_full),
    .empty (ibuf_empty),
    .count (ibuf_count)
  );

  // Remembers the PC of each accepted request so the in-order response can
  // be tagged. Dropped responses never pop it: the queue was already cleared
  // by the redirect that made them stale.
  fetch_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .elem_t (logic [31:0])
  ) u_pcq (
    .clk   (clk),
    .reset (reset),
    .push  (req_fire),
    .pop   (rsp_keep),
    .clear (redirect),
    .din   (pc),
    .dout  (pcq_pc),
    .full  (pcq_full),
    .empty (pcq_empty),
    .count (pcq_count)
  );

  assign if_instr    = ibuf_dout.instr;
  assign if_pc       = ibuf_dout.pc;
  assign if_pc_plus4 = ibuf_empty ? 32'h0 : (ibuf_dout.pc + 32'(INSTR_BYTES));

  // Status the stage does not need; the occupancy cap already rules out
  // overflow of either queue.
  logic unused_ok;
  assign unused_ok = &{1'b0, ibuf_full, pcq_full, pcq_empty, pcq_count};

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Scoreboard bench for fetch_unit. A one-cycle-latency memory model answers
//   accepted requests in order; every response the bench expects to reach
//   decode is pushed to a scoreboard and popped when decode takes an entry.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        branch_decision = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        misaligned_target;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .branch_decision   (branch_decision),
    .branch_target     (branch_target),
    .imem_req_valid    (imem_req_valid),
    .imem_req_ready    (imem_req_ready),
    .imem_addr         (imem_addr),
    .imem_rsp_valid    (imem_rsp_valid),
    .imem_rsp_data     (imem_rsp_data),
    .if_valid          (if_valid),
    .if_ready          (if_ready),
    .if_instr          (if_instr),
    .if_pc             (if_pc),
    .if_pc_plus4       (if_pc_plus4),
    .misaligned_target (misaligned_target)
  );

  typedef struct {
    logic [31:0] addr;
    int          issued;
    bit          stale;
  } mem_req_t;

  mem_req_t    pending[$];
  FetchEntry   sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          since_reset = 0;
  int          req_count = 0;
  logic [31:0] exp_pc = RESET_PC;
  bit          exp_mis = 1'b0;
  bit          mem_stall = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
  endfunction

  // One clock cycle, entered and left at a falling edge. The caller sets the
  // decode/branch inputs beforehand; the memory model drives the response.
  task automatic cycle();
    mem_req_t  head;
    bit        rsp_now;
    bit        redir;
    bit        exp_valid;
    FetchEntry want;
    rsp_now = 1'b0;
    head = '{addr: 32'h0, issued: 0, stale: 1'b0};
    if (!mem_stall && pending.size() > 0 && pending[0].issued < cyc) begin
      head = pending.pop_front();
      rsp_now = 1'b1;
    end
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_word(head.addr) : 32'h0;
    #1;
    redir = branch_decision && (since_reset > 0);

    vectors++;
    if (misaligned_target !== exp_mis) begin
      miscompares++;
      $display("FAIL misaligned_target cyc=%0d: got %b want %b", cyc, misaligned_target, exp_mis);
    end

    exp_valid = (sb.size() > 0) && !branch_decision;
    vectors++;
    if (if_valid !== exp_valid) begin
      miscompares++;
      $display("FAIL if_valid cyc=%0d: got %b want %b", cyc, if_valid, exp_valid);
    end
    if (if_valid === 1'b1 && if_ready && sb.size() > 0) begin
      want = sb.pop_front();
      vectors++;
      if (if_pc !== want.pc || if_instr !== want.instr || if_pc_plus4 !== want.pc + 32'd4) begin
        miscompares++;
        $display("FAIL decode_entry cyc=%0d: got pc=%h instr=%h plus4=%h want pc=%h instr=%h plus4=%h",
                 cyc, if_pc, if_instr, if_pc_plus4, want.pc, want.instr, want.pc + 32'd4);
      end
    end

    if (branch_decision) begin
      vectors++;
      if (imem_req_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL req_during_redirect cyc=%0d: got %b want 0", cyc, imem_req_valid);
      end
    end
    if (imem_req_valid === 1'b1 && imem_req_ready) begin
      vectors++;
      if (imem_addr !== exp_pc) begin
        miscompares++;
        $display("FAIL imem_addr cyc=%0d: got %h want %h", cyc, imem_addr, exp_pc);
      end
      pending.push_back('{addr: exp_pc, issued: cyc, stale: 1'b0});
      exp_pc = exp_pc + 32'd4;
      req_count++;
    end

    vectors++;
    if (dut.ibuf_push && dut.ibuf_full && !dut.ibuf_pop) begin
      miscompares++;
      $display("FAIL ibuf_overflow cyc=%0d: push while full without pop", cyc);
    end

    if (redir) begin
      sb.delete();
      foreach (pending[i]) pending[i].stale = 1'b1;
      exp_pc = {branch_target[31:2], 2'b00};
    end
    if (rsp_now && !head.stale && !redir)
      sb.push_back('{instr: mem_word(head.addr), pc: head.addr});
    exp_mis = redir && (branch_target[1:0] != 2'b00);

    @(posedge clk);
    cyc++;
    since_reset++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    branch_decision = 1'b0;
    branch_target   = '0;
    if_ready        = 1'b0;
    imem_req_ready  = 1'b1;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = '0;
    mem_stall       = 1'b0;
  endtask

  task automatic clear_model();
    sb.delete();
    foreach (pending[i]) pending[i].stale = 1'b1;
    exp_pc    = RESET_PC;
    exp_mis   = 1'b0;
    req_count = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    clear_model();
    pending.delete();
    @(negedge clk);
    reset = 1'b0;
    since_reset = 0;
  endtask

  task automatic check_cleared(input string tag);
    vectors++;
    if ({imem_req_valid, if_valid, misaligned_target} !== 3'b000 || imem_addr !== RESET_PC ||
        {if_instr, if_pc, if_pc_plus4} !== 96'h0) begin
      miscompares++;
      $display("FAIL %s: got req=%b valid=%b mis=%b addr=%h instr=%h pc=%h plus4=%h want all 0, addr=%h",
               tag, imem_req_valid, if_valid, misaligned_target, imem_addr, if_instr, if_pc,
               if_pc_plus4, RESET_PC);
    end
  endtask

  // Bounded wait for decode to present an entry.
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    #1;
    while (if_valid !== 1'b1 && n < 12) begin
      cycle();
      #1;
      n++;
    end
    if (n >= 12) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no if_valid within 12 cycles, want if_valid=1", tag);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    check_cleared("reset_outputs");
    do_reset();
    #1;
    vectors++;
    if (imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL boot_no_request: got %b want 0", imem_req_valid);
    end
  endtask

  task automatic test_stream();
    do_reset();
    if_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      vectors++;
      if (if_valid !== (i >= 4)) begin
        miscompares++;
        $display("FAIL stream_valid cycle%0d: got %b want %b", i, if_valid, (i >= 4));
      end
      if (i >= 4 && i <= 7) begin
        vectors++;
        if (if_pc !== 32'((i - 4) * 4) || if_pc_plus4 !== 32'((i - 3) * 4)) begin
          miscompares++;
          $display("FAIL stream_pc cycle%0d: got pc=%h plus4=%h want pc=%h plus4=%h",
                   i, if_pc, if_pc_plus4, 32'((i - 4) * 4), 32'((i - 3) * 4));
        end
      end
      cycle();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    if_ready = 1'b0;
    repeat (6) cycle();
    #1;
    vectors++;
    if (req_count !== 2 || imem_req_valid !== 1'b0 || if_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_cap: got reqs=%0d req_valid=%b if_valid=%b want reqs=2 req_valid=0 if_valid=1",
               req_count, imem_req_valid, if_valid);
    end
    if_ready = 1'b1;
    #1;
    vectors++;
    if (if_pc !== 32'd0 || imem_req_valid !== 1'b1 || imem_addr !== 32'd8) begin
      miscompares++;
      $display("FAIL stall_resume: got pc=%h req=%b addr=%h want pc=0 req=1 addr=8",
               if_pc, imem_req_valid, imem_addr);
    end
    cycle();
    #1;
    vectors++;
    if (if_valid !== 1'b1 || if_pc !== 32'd4) begin
      miscompares++;
      $display("FAIL stall_second: got valid=%b pc=%h want valid=1 pc=4", if_valid, if_pc);
    end
    repeat (4) cycle();
  endtask

  task automatic test_flush();
    do_reset();
    if_ready = 1'b1;
    repeat (4) cycle();
    mem_stall = 1'b1;
    repeat (2) cycle();
    #1;
    vectors++;
    if (imem_req_valid !== 1'b0 || pending.size() != 2) begin
      miscompares++;
      $display("FAIL flush_setup: got req=%b pending=%0d want req=0 pending=2",
               imem_req_valid, pending.size());
    end
    branch_decision = 1'b1;
    branch_target   = 32'd120;
    cycle();
    branch_decision = 1'b0;
    mem_stall       = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (imem_req_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_hold%0d: got req=%b want 0", i, imem_req_valid);
      end
      cycle();
    end
    #1;
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'd120) begin
      miscompares++;
      $display("FAIL flush_resume: got req=%b addr=%h want req=1 addr=00000078", imem_req_valid, imem_addr);
    end
    wait_valid("flush");
    vectors++;
    if (if_pc !== 32'd120) begin
      miscompares++;
      $display("FAIL flush_first_pc: got %h want 00000078", if_pc);
    end
    cycle();
    #1;
    vectors++;
    if (if_valid !== 1'b1 || if_pc !== 32'd124) begin
      miscompares++;
      $display("FAIL flush_second_pc: got valid=%b pc=%h want valid=1 pc=0000007c", if_valid, if_pc);
    end
    repeat (3) cycle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    if_ready = 1'b1;
    repeat (6) cycle();
    #1;
    vectors++;
    if (imem_req_valid !== 1'b1 || pending.size() != 1) begin
      miscompares++;
      $display("FAIL collide_setup: got req=%b pending=%0d want req=1 pending=1",
               imem_req_valid, pending.size());
    end
    branch_decision = 1'b1;
    branch_target   = 32'd120;
    cycle();
    branch_decision = 1'b0;
    #1;
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'd120) begin
      miscompares++;
      $display("FAIL collide_next_addr: got req=%b addr=%h want req=1 addr=00000078", imem_req_valid, imem_addr);
    end
    wait_valid("collide");
    vectors++;
    if (if_pc !== 32'd120) begin
      miscompares++;
      $display("FAIL collide_first_pc: got %h want 00000078", if_pc);
    end
    repeat (4) cycle();
  endtask

  task automatic test_misaligned();
    do_reset();
    if_ready = 1'b1;
    repeat (6) cycle();
    branch_decision = 1'b1;
    branch_target   = 32'd25;
    cycle();
    branch_decision = 1'b0;
    #1;
    vectors++;
    if (misaligned_target !== 1'b1 || imem_req_valid !== 1'b1 || imem_addr !== 32'd24) begin
      miscompares++;
      $display("FAIL misaligned_redirect: got mis=%b req=%b addr=%h want mis=1 req=1 addr=00000018",
               misaligned_target, imem_req_valid, imem_addr);
    end
    cycle();
    #1;
    vectors++;
    if (misaligned_target !== 1'b0) begin
      miscompares++;
      $display("FAIL misaligned_pulse_width: got %b want 0", misaligned_target);
    end
    wait_valid("misaligned");
    vectors++;
    if (if_pc !== 32'd24) begin
      miscompares++;
      $display("FAIL misaligned_pc: got %h want 00000018", if_pc);
    end
    repeat (3) cycle();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    if_ready = 1'b1;
    repeat (4) cycle();
    mem_stall = 1'b1;
    repeat (2) cycle();
    #2;
    reset = 1'b1;
    #1;
    check_cleared("midstream_reset_outputs");
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    since_reset = 0;
    mem_stall = 1'b0;
    wait_valid("midstream");
    vectors++;
    if (if_pc !== RESET_PC || if_instr !== mem_word(RESET_PC)) begin
      miscompares++;
      $display("FAIL midstream_first: got pc=%h instr=%h want pc=%h instr=%h",
               if_pc, if_instr, RESET_PC, mem_word(RESET_PC));
    end
    repeat (4) cycle();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_misaligned();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200us, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
